ex_issue_stage: RTL and testbench

// ID/EX pipeline stage directly upstream of the ALU. Captures a decoded instruction from ID,

---
 rtl/cpu_pkg.sv | 65 ++++++
 rtl/fwd_unit.sv | 35 +++
 rtl/ex_issue_stage.sv | 136 +++++++++++++
 tb/tb_ex_issue_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes, forwarding select
// encoding, the ID/EX slot record and the regfile write-through helper.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 5;

    // ALU opcode encoding
    localparam logic [CTRL_W-1:0] ALU_ADD  = 5'b00000;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 5'b00001;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 5'b00010;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 5'b00011;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 5'b00100;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 5'b00101;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 5'b00110;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 5'b00111;
    localparam logic [CTRL_W-1:0] ALU_OR   = 5'b01000;
    localparam logic [CTRL_W-1:0] ALU_AND  = 5'b01001;
    localparam logic [CTRL_W-1:0] ALU_JAL  = 5'b01010;
    localparam logic [CTRL_W-1:0] ALU_BEQ  = 5'b01011;
    localparam logic [CTRL_W-1:0] ALU_BNE  = 5'b01100;
    localparam logic [CTRL_W-1:0] ALU_BLT  = 5'b01101;
    localparam logic [CTRL_W-1:0] ALU_BGE  = 5'b01110;
    localparam logic [CTRL_W-1:0] ALU_BLTU = 5'b01111;
    localparam logic [CTRL_W-1:0] ALU_BGEU = 5'b10000;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 5'b10001;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] alu_control;
        logic [XLEN-1:0]   pc;
        logic [RA_W-1:0]   rs1_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [RA_W-1:0]   rs2_addr;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic              src1_pc;
        logic              src2_imm;
        logic [RA_W-1:0]   rd_addr;
        logic              rd_we;
        logic              mem_read;
        logic              mem_write;
    } ex_slot_t;

    // Regfile write-through: a WB write in the same cycle as the ID read
    // is not yet visible in the regfile data, so substitute it here.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] data,
        input logic [RA_W-1:0] wb_addr,
        input logic            wb_we,
        input logic [XLEN-1:0] wb_data
    );
        if (addr != '0 && wb_we && wb_addr == addr) return wb_data;
        return data;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding for one source register: x0 reads zero, a non-load MEM
// result beats a WB result, otherwise the slot's own data is used.
module fwd_unit
    import cpu_pkg::*;
(
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic            mem_rd_we,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] mem_rd_data,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_rd_data,
    output logic [XLEN-1:0] fwd_data,
    output fwd_sel_e        fwd_sel
);

    // Priority select: x0, then MEM, then WB, then slot data
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        fwd_sel  = FWD_RF;
        fwd_data = rs_data;
        if (rs_addr == '0) begin
            fwd_data = '0;
        end else if (mem_rd_we && !mem_is_load && mem_rd_addr == rs_addr) begin
            fwd_sel  = FWD_MEM;
            fwd_data = mem_rd_data;
        end else if (wb_rd_we && wb_rd_addr == rs_addr) begin
            fwd_sel  = FWD_WB;
            fwd_data = wb_rd_data;
        end
    end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline slot feeding the ALU: valid/ready handshake with ID,
// load-use bubble, flush of the younger instruction and operand forwarding.
module ex_issue_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [RA_W-1:0]   id_rs1_addr,
    input  logic              id_rs1_used,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [RA_W-1:0]   id_rs2_addr,
    input  logic              id_rs2_used,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_src1_pc,
    input  logic              id_src2_imm,
    input  logic [RA_W-1:0]   id_rd_addr,
    input  logic              id_rd_we,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic [RA_W-1:0]   mem_rd_addr,
    input  logic              mem_rd_we,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic              mem_is_load,
    input  logic [RA_W-1:0]   wb_rd_addr,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_rd_data,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] alu_control,
    output logic [XLEN-1:0]   alu_in1,
    output logic [XLEN-1:0]   alu_in2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic              ex_rd_we,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    ex_slot_t        slot_q, slot_d;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
    fwd_sel_e        fwd1_sel, fwd2_sel;
    logic            advance, load, load_use;

    fwd_unit u_fwd1 (
        .rs_addr     (slot_q.rs1_addr),
        .rs_data     (slot_q.rs1_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_we   (mem_rd_we),
        .mem_is_load (mem_is_load),
        .mem_rd_data (mem_rd_data),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .wb_rd_data  (wb_rd_data),
        .fwd_data    (fwd1_data),
        .fwd_sel     (fwd1_sel)
    );

    fwd_unit u_fwd2 (
        .rs_addr     (slot_q.rs2_addr),
        .rs_data     (slot_q.rs2_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_we   (mem_rd_we),
        .mem_is_load (mem_is_load),
        .mem_rd_data (mem_rd_data),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_we    (wb_rd_we),
        .wb_rd_data  (wb_rd_data),
        .fwd_data    (fwd2_data),
        .fwd_sel     (fwd2_sel)
    );

    // A load in the slot cannot forward to its direct consumer: stall ID one cycle
    assign load_use = slot_q.valid && slot_q.mem_read && (slot_q.rd_addr != '0) &&
                      ((id_rs1_used && id_rs1_addr == slot_q.rd_addr) ||
                       (id_rs2_used && id_rs2_addr == slot_q.rd_addr));
    assign id_ready = (!slot_q.valid || ex_ready) && !load_use && !flush;
    assign advance  = slot_q.valid && ex_ready;
    assign load     = id_valid && id_ready;

    // Next slot: capture from ID, bubble on advance, or hold with operand refresh
    always_comb begin
        slot_d = slot_q;
        if (load) begin
            slot_d.valid       = 1'b1;
            slot_d.alu_control = id_alu_control;
            slot_d.pc          = id_pc;
            slot_d.rs1_addr    = id_rs1_addr;
            slot_d.rs1_data    = wb_bypass(id_rs1_addr, id_rs1_data, wb_rd_addr, wb_rd_we, wb_rd_data);
            slot_d.rs2_addr    = id_rs2_addr;
            slot_d.rs2_data    = wb_bypass(id_rs2_addr, id_rs2_data, wb_rd_addr, wb_rd_we, wb_rd_data);
            slot_d.imm         = id_imm;
            slot_d.src1_pc     = id_src1_pc;
            slot_d.src2_imm    = id_src2_imm;
            slot_d.rd_addr     = id_rd_addr;
            slot_d.rd_we       = id_rd_we;
            slot_d.mem_read    = id_mem_read;
            slot_d.mem_write   = id_mem_write;
        end else if (advance) begin
            slot_d.valid = 1'b0;
        end else if (slot_q.valid) begin
            // Latch forwarded values so they outlive the producer leaving WB
            if (fwd1_sel != FWD_RF) slot_d.rs1_data = fwd1_data;
            if (fwd2_sel != FWD_RF) slot_d.rs2_data = fwd2_data;
        end
    end

    // Slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole slot is cleared, not just valid, so reset leaves no stale operands behind.
            slot_q <= '0;
        end else begin
            // NOTE: non-blocking so every reader of slot_q sees the pre-edge value this cycle.
            slot_q <= slot_d;
        end
    end

    assign ex_valid      = slot_q.valid;
    assign alu_control   = slot_q.valid ? slot_q.alu_control : '0;
    assign alu_in1       = !slot_q.valid ? '0 : (slot_q.src1_pc  ? slot_q.pc  : fwd1_data);
    assign alu_in2       = !slot_q.valid ? '0 : (slot_q.src2_imm ? slot_q.imm : fwd2_data);
    assign ex_store_data = slot_q.valid ? fwd2_data : '0;
    assign ex_pc         = slot_q.pc;
    assign ex_rd_addr    = slot_q.rd_addr;
    assign ex_rd_we      = slot_q.valid && slot_q.rd_we;
    assign ex_mem_read   = slot_q.valid && slot_q.mem_read;
    assign ex_mem_write  = slot_q.valid && slot_q.mem_write;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: reset, MEM/WB forwarding, load-use
// bubble, x0 protection, hold refresh and flush with MEM-over-WB priority.
module tb_ex_issue_stage;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid, id_ready;
    logic [CTRL_W-1:0] id_alu_control;
    logic [XLEN-1:0]   id_pc;
    logic [RA_W-1:0]   id_rs1_addr, id_rs2_addr;
    logic              id_rs1_used, id_rs2_used;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
    logic              id_src1_pc, id_src2_imm;
    logic [RA_W-1:0]   id_rd_addr;
    logic              id_rd_we, id_mem_read, id_mem_write;
    logic              ex_ready, flush;
    logic [RA_W-1:0]   mem_rd_addr, wb_rd_addr;
    logic              mem_rd_we, mem_is_load, wb_rd_we;
    logic [XLEN-1:0]   mem_rd_data, wb_rd_data;
    logic              ex_valid;
    logic [CTRL_W-1:0] alu_control;
    logic [XLEN-1:0]   alu_in1, alu_in2, ex_store_data, ex_pc;
    logic [RA_W-1:0]   ex_rd_addr;
    logic              ex_rd_we, ex_mem_read, ex_mem_write;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_control(id_alu_control), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used), .id_rs1_data(id_rs1_data),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .ex_ready(ex_ready), .flush(flush),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_rd_data(mem_rd_data),
        .mem_is_load(mem_is_load),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_rd_data(wb_rd_data),
        .ex_valid(ex_valid), .alu_control(alu_control),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_alu_control = '0; id_pc = '0;
        id_rs1_addr = '0; id_rs1_used = 1'b0; id_rs1_data = '0;
        id_rs2_addr = '0; id_rs2_used = 1'b0; id_rs2_data = '0;
        id_imm = '0; id_src1_pc = 1'b0; id_src2_imm = 1'b0;
        id_rd_addr = '0; id_rd_we = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        ex_ready = 1'b1; flush = 1'b0;
        mem_rd_addr = '0; mem_rd_we = 1'b0; mem_rd_data = '0; mem_is_load = 1'b0;
        wb_rd_addr = '0; wb_rd_we = 1'b0; wb_rd_data = '0;
    endtask

    task automatic drive_id(input logic [CTRL_W-1:0] ctrl, input logic [XLEN-1:0] pc,
                            input logic [RA_W-1:0] rs1, input logic rs1_used, input logic [XLEN-1:0] rs1_data,
                            input logic [RA_W-1:0] rs2, input logic rs2_used, input logic [XLEN-1:0] rs2_data,
                            input logic [XLEN-1:0] imm, input logic src1_pc, input logic src2_imm,
                            input logic [RA_W-1:0] rd, input logic rd_we, input logic mem_rd);
        id_valid = 1'b1; id_alu_control = ctrl; id_pc = pc;
        id_rs1_addr = rs1; id_rs1_used = rs1_used; id_rs1_data = rs1_data;
        id_rs2_addr = rs2; id_rs2_used = rs2_used; id_rs2_data = rs2_data;
        id_imm = imm; id_src1_pc = src1_pc; id_src2_imm = src2_imm;
        id_rd_addr = rd; id_rd_we = rd_we; id_mem_read = mem_rd; id_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        // Power-on reset state
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL por_ex_valid got=%0h exp=0", ex_valid); end
        n_cmp++; if (alu_control !== '0) begin n_fail++; $display("FAIL por_alu_control got=%0h exp=0", alu_control); end
        n_cmp++; if (ex_pc !== '0) begin n_fail++; $display("FAIL por_ex_pc got=%0h exp=0", ex_pc); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL por_id_ready got=%0h exp=1", id_ready); end
        // Load an instruction, hold it, then reset mid-hold
        drive_id(ALU_ADD, 32'h100, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h55, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        step();
        id_valid = 1'b0; ex_ready = 1'b0; #1;
        n_cmp++; if (alu_in1 !== 32'h100) begin n_fail++; $display("FAIL hold_pre_reset_in1 got=%0h exp=100", alu_in1); end
        rst_n = 1'b0; #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid got=%0h exp=0", ex_valid); end
        n_cmp++; if (alu_in1 !== '0) begin n_fail++; $display("FAIL rst_alu_in1 got=%0h exp=0", alu_in1); end
        n_cmp++; if (ex_rd_we !== 1'b0) begin n_fail++; $display("FAIL rst_rd_we got=%0h exp=0", ex_rd_we); end
        @(negedge clk); rst_n = 1'b1; ex_ready = 1'b1; #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL rst_id_ready got=%0h exp=1", id_ready); end
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stays_empty got=%0h exp=0", ex_valid); end
    endtask

    task automatic test_mem_fwd();
        clear_inputs();
        // ADDI x1, x0, 5
        drive_id(ALU_ADD, 32'h200, 5'd0, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 32'd5, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0);
        step();
        n_cmp++; if (alu_in2 !== 32'd5) begin n_fail++; $display("FAIL addi_in2 got=%0h exp=5", alu_in2); end
        n_cmp++; if (ex_rd_addr !== 5'd1 || ex_rd_we !== 1'b1) begin n_fail++; $display("FAIL addi_rd got=%0h/%0h exp=1/1", ex_rd_addr, ex_rd_we); end
        // ADD x2, x1, x1 with stale regfile data
        drive_id(ALU_ADD, 32'h204, 5'd1, 1'b1, 32'h0, 5'd1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
        #1;
        n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL add_id_ready got=%0h exp=1", id_ready); end
        step();
        id_valid = 1'b0;
        mem_rd_addr = 5'd1; mem_rd_we = 1'b1; mem_rd_data = 32'd5; mem_is_load = 1'b0; #1;
        n_cmp++; if (alu_in1 !== 32'd5) begin n_fail++; $display("FAIL memfwd_in1 got=%0h exp=5", alu_in1); end
        n_cmp++; if (alu_in2 !== 32'd5) begin n_fail++; $display("FAIL memfwd_in2 got=%0h exp=5", alu_in2); end
        n_cmp++; if (ex_pc !== 32'h204) begin n_fail++; $display("FAIL memfwd_pc got=%0h exp=204", ex_pc); end
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        // LW x3, 16(x0)
        drive_id(ALU_ADD, 32'h300, 5'd0, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 32'h10, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1);
        step();
        n_cmp++; if (ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL lw_mem_read got=%0h exp=1", ex_mem_read); end
        // ADD x4, x3, x0
        drive_id(ALU_ADD, 32'h304, 5'd3, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        #1;
        n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_id_ready got=%0h exp=0", id_ready); end
        step();
        mem_rd_addr = 5'd3; mem_rd_we = 1'b1; mem_rd_data = 32'h999; mem_is_load = 1'b1; #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%0h exp=0", ex_valid); end
        n_cmp++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready_after got=%0h exp=1", id_ready); end
        step();
        id_valid = 1'b0;
        mem_rd_addr = '0; mem_rd_we = 1'b0; mem_is_load = 1'b0;
        wb_rd_addr = 5'd3; wb_rd_we = 1'b1; wb_rd_data = 32'h1234; #1;
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_consumer_valid got=%0h exp=1", ex_valid); end
        n_cmp++; if (alu_in1 !== 32'h1234) begin n_fail++; $display("FAIL lu_wbfwd_in1 got=%0h exp=1234", alu_in1); end
        step();
    endtask

    task automatic test_x0();
        clear_inputs();
        drive_id(ALU_ADD, 32'h400, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        id_valid = 1'b0;
        mem_rd_addr = 5'd0; mem_rd_we = 1'b1; mem_rd_data = 32'hDEAD;
        wb_rd_addr = 5'd0; wb_rd_we = 1'b1; wb_rd_data = 32'hDEAD; #1;
        n_cmp++; if (alu_in1 !== '0) begin n_fail++; $display("FAIL x0_in1 got=%0h exp=0", alu_in1); end
        n_cmp++; if (alu_in2 !== '0) begin n_fail++; $display("FAIL x0_in2 got=%0h exp=0", alu_in2); end
        n_cmp++; if (ex_store_data !== '0) begin n_fail++; $display("FAIL x0_store got=%0h exp=0", ex_store_data); end
        step();
    endtask

    task automatic test_hold();
        clear_inputs();
        // ADD x5, x6, x7 with x6=3 current and x7 stale
        drive_id(ALU_ADD, 32'h500, 5'd6, 1'b1, 32'd3, 5'd7, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_rd_addr = 5'd7; wb_rd_we = 1'b1; wb_rd_data = 32'd7; #1;
        n_cmp++; if (alu_in2 !== 32'd7) begin n_fail++; $display("FAIL hold_c1_in2 got=%0h exp=7", alu_in2); end
        n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL hold_id_ready got=%0h exp=0", id_ready); end
        step();
        wb_rd_addr = '0; wb_rd_we = 1'b0; wb_rd_data = '0; #1;
        n_cmp++; if (alu_in2 !== 32'd7) begin n_fail++; $display("FAIL hold_c2_in2 got=%0h exp=7", alu_in2); end
        n_cmp++; if (alu_in1 !== 32'd3) begin n_fail++; $display("FAIL hold_c2_in1 got=%0h exp=3", alu_in1); end
        step();
        n_cmp++; if (alu_in2 !== 32'd7) begin n_fail++; $display("FAIL hold_c3_in2 got=%0h exp=7", alu_in2); end
        n_cmp++; if (ex_store_data !== 32'd7) begin n_fail++; $display("FAIL hold_c3_store got=%0h exp=7", ex_store_data); end
        n_cmp++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL hold_c3_valid got=%0h exp=1", ex_valid); end
        ex_ready = 1'b1;
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got=%0h exp=0", ex_valid); end
    endtask

    task automatic test_flush_prio();
        clear_inputs();
        // BEQ-like slot instruction reading x9
        drive_id(ALU_BEQ, 32'h600, 5'd9, 1'b1, 32'd1, 5'd0, 1'b0, 32'h0, 32'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step();
        // Younger instruction offered while flush is asserted
        drive_id(ALU_ADD, 32'h604, 5'd1, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        mem_rd_addr = 5'd9; mem_rd_we = 1'b1; mem_rd_data = 32'hAAAA; mem_is_load = 1'b0;
        wb_rd_addr = 5'd9; wb_rd_we = 1'b1; wb_rd_data = 32'hBBBB; #1;
        n_cmp++; if (alu_in1 !== 32'hAAAA) begin n_fail++; $display("FAIL prio_in1 got=%0h exp=AAAA", alu_in1); end
        n_cmp++; if (alu_control !== ALU_BEQ) begin n_fail++; $display("FAIL prio_ctrl got=%0h exp=%0h", alu_control, ALU_BEQ); end
        n_cmp++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_id_ready got=%0h exp=0", id_ready); end
        step();
        n_cmp++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid got=%0h exp=0", ex_valid); end
        n_cmp++; if (ex_rd_we !== 1'b0) begin n_fail++; $display("FAIL flush_rd_we got=%0h exp=0", ex_rd_we); end
        clear_inputs();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        test_reset();
        test_mem_fwd();
        test_load_use();
        test_x0();
        test_hold();
        test_flush_prio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
